// File: rtl/queue_detector.sv
// Loop-detector conditioning: synchronise, debounce and edge-detect the main/cross arrival and
// departure loops, then keep saturating queue counts with hysteretic queue-present flags.
module queue_detector #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 6,
    parameter int unsigned MAX_Q           = 63,
    parameter int unsigned ON_TH           = 3,
    parameter int unsigned OFF_TH          = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arr_m,
    input  logic             dep_m,
    input  logic             arr_c,
    input  logic             dep_c,
    input  logic             clr,
    output logic             PQm,
    output logic             PQc,
    output logic [CNT_W-1:0] q_m,
    output logic [CNT_W-1:0] q_c,
    output logic [1:0]       ovf
);

    localparam int unsigned DC_W = $clog2(DEBOUNCE_CYCLES);

    // Channel order: [0]=arr_m, [1]=dep_m, [2]=arr_c, [3]=dep_c
    logic [3:0]      raw;
    logic [3:0]      sync1_q, sync2_q;
    logic [3:0]      deb_q, deb_d, deb_prev_q;
    logic [3:0]      ev;
    logic [DC_W-1:0] dc_q [4];
    logic [DC_W-1:0] dc_d [4];

    logic [1:0]       ev_arr, ev_dep;
    logic [CNT_W-1:0] q_q [2];
    logic [CNT_W-1:0] q_d [2];
    logic [1:0]       pq_q, pq_d;
    logic [1:0]       ovf_q, ovf_d;

    assign raw = {dep_c, arr_c, dep_m, arr_m};

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            dc_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (dc_q[i] == DC_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    dc_d[i] = dc_q[i] + DC_W'(1);
                end
            end
        end
    end

    assign ev     = deb_q & ~deb_prev_q;
    assign ev_arr = {ev[2], ev[0]};
    assign ev_dep = {ev[3], ev[1]};

    // Simultaneous arrival and departure cancel: no count change and no overflow.
    always_comb begin
        pq_d  = pq_q;
        ovf_d = ovf_q;
        for (int r = 0; r < 2; r++) begin
            q_d[r] = q_q[r];
            if (ev_arr[r] && !ev_dep[r]) begin
                if (q_q[r] == CNT_W'(MAX_Q)) begin
                    ovf_d[r] = 1'b1;
                end else begin
                    q_d[r] = q_q[r] + CNT_W'(1);
                end
            end else if (ev_dep[r] && !ev_arr[r]) begin
                if (q_q[r] != '0) begin
                    q_d[r] = q_q[r] - CNT_W'(1);
                end
            end
            if (q_d[r] >= CNT_W'(ON_TH)) begin
                pq_d[r] = 1'b1;
            end else if (q_d[r] <= CNT_W'(OFF_TH)) begin
                pq_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            dc_q       <= '{default: '0};
            q_q        <= '{default: '0};
            pq_q       <= '0;
            ovf_q      <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            dc_q       <= dc_d;
            // clr leaves the debouncers alone so a parked vehicle does not re-count.
            if (clr) begin
                q_q   <= '{default: '0};
                pq_q  <= '0;
                ovf_q <= '0;
            end else begin
                q_q   <= q_d;
                pq_q  <= pq_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign q_m = q_q[0];
    assign q_c = q_q[1];
    assign PQm = pq_q[0];
    assign PQc = pq_q[1];
    assign ovf = ovf_q;

endmodule
